// File: rtl/cmd_stream_dma_reader.sv
// Command-list fetcher: reads N beats from AXI memory in INCR bursts and replays
// them as an AXI Stream. A credit counter sized to the FIFO bounds outstanding reads.
module cmd_stream_dma_reader #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 64,
  parameter int ID_WIDTH      = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int FIFO_DEPTH    = 32
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [23:0]           start_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_error,
  output logic [ID_WIDTH-1:0]   m_mem_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_mem_axi_araddr,
  output logic [7:0]            m_mem_axi_arlen,
  output logic [2:0]            m_mem_axi_arsize,
  output logic [1:0]            m_mem_axi_arburst,
  output logic                  m_mem_axi_arlock,
  output logic [3:0]            m_mem_axi_arcache,
  output logic [2:0]            m_mem_axi_arprot,
  output logic                  m_mem_axi_arvalid,
  input  logic                  m_mem_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_mem_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_mem_axi_rdata,
  input  logic [1:0]            m_mem_axi_rresp,
  input  logic                  m_mem_axi_rlast,
  input  logic                  m_mem_axi_rvalid,
  output logic                  m_mem_axi_rready,
  output logic                  m_cmd_axis_tvalid,
  input  logic                  m_cmd_axis_tready,
  output logic                  m_cmd_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_cmd_axis_tdata
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BSHIFT = $clog2(BYTES);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CNTW   = PW + 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  // Burst length limited by remaining beats, max burst and the next 4 KiB page.
  function automatic logic [8:0] calc_blen(input logic [11:0] a_lo, input logic [23:0] left);
    logic [12:0] to_bnd;
    logic [24:0] b;
    to_bnd = (13'h1000 - {1'b0, a_lo}) >> BSHIFT;
    b = {1'b0, left};
    if (b > 25'(MAX_BURST_LEN)) b = 25'(MAX_BURST_LEN);
    if (b > {12'd0, to_bnd})    b = {12'd0, to_bnd};
    return b[8:0];
  endfunction

  state_e                state_q;
  logic                  busy_q, done_q, rd_error_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [23:0]           req_left_q, out_left_q;
  logic [CW-1:0]         credits_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]       cnt_q;
  logic                  tvalid_q;
  logic [DATA_WIDTH-1:0] tdata_q;

  logic [8:0] blen, blen0;
  logic       ar_hs, r_hs, ax_hs;
  logic       fifo_load, pop, byp, push;
  logic       unused_in;

  assign unused_in = ^{m_mem_axi_rid, m_mem_axi_rlast};

  assign blen  = calc_blen(addr_q[11:0], req_left_q);
  assign blen0 = calc_blen(start_addr[11:0], start_beats);
  assign ar_hs = arvalid_q & m_mem_axi_arready;
  assign r_hs  = busy_q & m_mem_axi_rvalid;
  assign ax_hs = tvalid_q & m_cmd_axis_tready;

  // Output register refills from the FIFO, or straight from R when the FIFO is empty.
  assign fifo_load = ~tvalid_q | m_cmd_axis_tready;
  assign pop       = fifo_load & (cnt_q != '0);
  assign byp       = fifo_load & (cnt_q == '0) & r_hs;
  assign push      = r_hs & ~byp;

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= m_mem_axi_rdata;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);
      if (fifo_load) begin
        tvalid_q <= pop | byp;
        if (pop)      tdata_q <= mem_q[rd_ptr_q];
        else if (byp) tdata_q <= m_mem_axi_rdata;
      end
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      credits_q <= CW'(FIFO_DEPTH);
    end else begin
      credits_q <= credits_q + CW'(ax_hs) - (ar_hs ? CW'(blen) : CW'(0));
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_error_q <= 1'b0;
      addr_q     <= '0;
      req_left_q <= '0;
      out_left_q <= '0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (r_hs && m_mem_axi_rresp != 2'b00) rd_error_q <= 1'b1;
      if (ax_hs) out_left_q <= out_left_q - 24'd1;
      case (state_q)
        IDLE: begin
          if (start) begin
            rd_error_q <= 1'b0;
            addr_q     <= start_addr;
            req_left_q <= start_beats;
            out_left_q <= start_beats;
            if (start_beats == 24'd0) begin
              done_q <= 1'b1;
            end else begin
              // Credits are full in IDLE, so the first burst goes out immediately.
              state_q   <= ISSUE;
              busy_q    <= 1'b1;
              arvalid_q <= 1'b1;
              araddr_q  <= start_addr;
              arlen_q   <= 8'(blen0 - 9'd1);
            end
          end
        end
        ISSUE: begin
          if (ar_hs) begin
            arvalid_q  <= 1'b0;
            addr_q     <= addr_q + (ADDR_WIDTH'(blen) << BSHIFT);
            req_left_q <= req_left_q - 24'(blen);
            if (req_left_q == 24'(blen)) state_q <= DRAIN;
          end else if (!arvalid_q && int'(credits_q) >= int'(blen)) begin
            arvalid_q <= 1'b1;
            araddr_q  <= addr_q;
            arlen_q   <= 8'(blen - 9'd1);
          end
        end
        DRAIN: begin
          if ((ax_hs && out_left_q == 24'd1) || out_left_q == 24'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign rd_error          = rd_error_q;
  assign m_mem_axi_arid    = '0;
  assign m_mem_axi_araddr  = araddr_q;
  assign m_mem_axi_arlen   = arlen_q;
  assign m_mem_axi_arsize  = 3'(BSHIFT);
  assign m_mem_axi_arburst = 2'b01;
  assign m_mem_axi_arlock  = 1'b0;
  assign m_mem_axi_arcache = 4'd0;
  assign m_mem_axi_arprot  = 3'd0;
  assign m_mem_axi_arvalid = arvalid_q;
  assign m_mem_axi_rready  = busy_q;
  assign m_cmd_axis_tvalid = tvalid_q;
  assign m_cmd_axis_tlast  = (out_left_q == 24'd1);
  assign m_cmd_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_cmd_stream_dma_reader.sv
// Scoreboard bench: stimulus queues expected ARs/beats, a negedge monitor checks handshakes,
// and a small memory model answers reads with data equal to the beat address.
module tb_cmd_stream_dma_reader;
  logic        aclk = 1'b0, resetn = 1'b0;
  logic        start = 1'b0;
  logic [23:0] start_addr = '0, start_beats = '0;
  logic        busy, done, rd_error;
  logic [7:0]  m_mem_axi_arid;
  logic [23:0] m_mem_axi_araddr;
  logic [7:0]  m_mem_axi_arlen;
  logic [2:0]  m_mem_axi_arsize;
  logic [1:0]  m_mem_axi_arburst;
  logic        m_mem_axi_arlock;
  logic [3:0]  m_mem_axi_arcache;
  logic [2:0]  m_mem_axi_arprot;
  logic        m_mem_axi_arvalid, m_mem_axi_arready = 1'b1;
  logic [7:0]  m_mem_axi_rid = '0;
  logic [63:0] m_mem_axi_rdata = '0;
  logic [1:0]  m_mem_axi_rresp = '0;
  logic        m_mem_axi_rlast = 1'b0;
  logic        m_mem_axi_rvalid = 1'b0, m_mem_axi_rready;
  logic        m_cmd_axis_tvalid, m_cmd_axis_tready = 1'b1, m_cmd_axis_tlast;
  logic [63:0] m_cmd_axis_tdata;

  cmd_stream_dma_reader dut (
    .aclk(aclk), .resetn(resetn), .start(start), .start_addr(start_addr),
    .start_beats(start_beats), .busy(busy), .done(done), .rd_error(rd_error),
    .m_mem_axi_arid(m_mem_axi_arid), .m_mem_axi_araddr(m_mem_axi_araddr),
    .m_mem_axi_arlen(m_mem_axi_arlen), .m_mem_axi_arsize(m_mem_axi_arsize),
    .m_mem_axi_arburst(m_mem_axi_arburst), .m_mem_axi_arlock(m_mem_axi_arlock),
    .m_mem_axi_arcache(m_mem_axi_arcache), .m_mem_axi_arprot(m_mem_axi_arprot),
    .m_mem_axi_arvalid(m_mem_axi_arvalid), .m_mem_axi_arready(m_mem_axi_arready),
    .m_mem_axi_rid(m_mem_axi_rid), .m_mem_axi_rdata(m_mem_axi_rdata),
    .m_mem_axi_rresp(m_mem_axi_rresp), .m_mem_axi_rlast(m_mem_axi_rlast),
    .m_mem_axi_rvalid(m_mem_axi_rvalid), .m_mem_axi_rready(m_mem_axi_rready),
    .m_cmd_axis_tvalid(m_cmd_axis_tvalid), .m_cmd_axis_tready(m_cmd_axis_tready),
    .m_cmd_axis_tlast(m_cmd_axis_tlast), .m_cmd_axis_tdata(m_cmd_axis_tdata)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [23:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [63:0] data; logic last; } beat_t;

  ar_t   exp_ar_q[$];
  beat_t exp_beat_q[$];
  ar_t   mem_q[$];
  int    errors = 0, checks = 0;
  int    done_cnt = 0, ar_cnt = 0, issued = 0, emitted = 0, max_out = 0;
  logic [23:0] err_addr = '1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake is compared against the head of its expectation queue.
  initial begin : monitor
    ar_t   g, e;
    beat_t b;
    logic  pv_stall;
    logic  pv_last;
    logic [63:0] pv_data;
    pv_stall = 1'b0; pv_last = 1'b0; pv_data = '0;
    forever begin
      @(negedge aclk);
      if (!resetn) begin
        issued = 0; emitted = 0; pv_stall = 1'b0;
        continue;
      end
      if (pv_stall) begin
        chk("axis_hold_vld_last", {62'd0, m_cmd_axis_tvalid, m_cmd_axis_tlast}, {62'd0, 1'b1, pv_last});
        chk("axis_hold_data", m_cmd_axis_tdata, pv_data);
      end
      if (m_mem_axi_arvalid && m_mem_axi_arready) begin
        g.addr = m_mem_axi_araddr; g.len = m_mem_axi_arlen;
        ar_cnt++;
        issued += int'(m_mem_axi_arlen) + 1;
        mem_q.push_back(g);
        if (exp_ar_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_unexpected: got addr %0h len %0d, none expected", g.addr, g.len);
        end else begin
          e = exp_ar_q.pop_front();
          chk("ar_addr", 64'(g.addr), 64'(e.addr));
          chk("ar_len", 64'(g.len), 64'(e.len));
        end
      end
      if (m_cmd_axis_tvalid && m_cmd_axis_tready) begin
        emitted++;
        if (exp_beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected: got data %0h, none expected", m_cmd_axis_tdata);
        end else begin
          b = exp_beat_q.pop_front();
          chk("beat_data", m_cmd_axis_tdata, b.data);
          chk("beat_last", 64'(m_cmd_axis_tlast), 64'(b.last));
        end
      end
      if (done) done_cnt++;
      if (issued - emitted > max_out) max_out = issued - emitted;
      pv_stall = m_cmd_axis_tvalid && !m_cmd_axis_tready;
      pv_data  = m_cmd_axis_tdata;
      pv_last  = m_cmd_axis_tlast;
    end
  end

  // Memory model: serves accepted bursts in order, data = byte address.
  initial begin : r_drv
    int          beat_left;
    logic [23:0] raddr;
    bit          fire;
    ar_t         a;
    beat_left = 0; raddr = '0; fire = 1'b0;
    forever begin
      @(negedge aclk);
      fire = m_mem_axi_rvalid && m_mem_axi_rready;
      @(posedge aclk); #1;
      if (!resetn) begin
        m_mem_axi_rvalid = 1'b0; beat_left = 0; mem_q.delete();
        continue;
      end
      if (fire) begin raddr += 24'd8; beat_left--; end
      if (beat_left == 0 && mem_q.size() > 0) begin
        a = mem_q.pop_front(); raddr = a.addr; beat_left = int'(a.len) + 1;
      end
      m_mem_axi_rvalid = (beat_left > 0);
      m_mem_axi_rdata  = 64'(raddr);
      m_mem_axi_rresp  = (raddr == err_addr) ? 2'd2 : 2'd0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic exp_ar(input logic [23:0] a, input logic [7:0] l);
    ar_t x;
    x.addr = a; x.len = l;
    exp_ar_q.push_back(x);
  endtask

  task automatic go(input logic [23:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data = 64'(a) + 64'(i * 8);
      b.last = (i == n - 1);
      exp_beat_q.push_back(b);
    end
    @(posedge aclk); #1;
    start = 1'b1; start_addr = a; start_beats = 24'(n);
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin cyc(1); n++; end
    chk(name, 64'(done_cnt > d0), 64'd1);
  endtask

  task automatic end_checks(input int d0, input string name);
    cyc(4);
    chk({name, "_done_once"}, 64'(done_cnt), 64'(d0 + 1));
    chk({name, "_queues_empty"}, 64'(exp_ar_q.size() + exp_beat_q.size()), 64'd0);
    chk({name, "_idle"}, {62'd0, busy, m_cmd_axis_tvalid}, 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, a0;
    #3;
    chk("rst_outs", 64'({busy, done, rd_error, m_mem_axi_arvalid, m_mem_axi_araddr, m_mem_axi_arlen,
                        m_mem_axi_rready, m_cmd_axis_tvalid, m_cmd_axis_tlast}), 64'd0);
    chk("rst_tdata", m_cmd_axis_tdata, 64'd0);
    chk("const_ar_fields", 64'({m_mem_axi_arsize, m_mem_axi_arburst, m_mem_axi_arid, m_mem_axi_arlock,
                               m_mem_axi_arcache, m_mem_axi_arprot}), 64'({3'd3, 2'b01, 8'd0, 1'b0, 4'd0, 3'd0}));
    #20 resetn = 1'b1;
    cyc(2);

    // Basic transfer
    d0 = done_cnt;
    exp_ar(24'h000100, 8'd4);
    go(24'h000100, 5);
    chk("t1_busy_arvalid_c1", 64'({busy, m_mem_axi_arvalid}), 64'd3);
    wait_done(d0, 200, "t1_done");
    end_checks(d0, "t1");

    // Burst split at MAX_BURST_LEN and the 4 KiB page
    d0 = done_cnt;
    exp_ar(24'h000FC0, 8'd7);
    exp_ar(24'h001000, 8'd15);
    exp_ar(24'h001080, 8'd15);
    exp_ar(24'h001100, 8'd0);
    go(24'h000FC0, 41);
    wait_done(d0, 400, "t2_done");
    end_checks(d0, "t2");

    // Back-pressure: credits stop issue at 32 outstanding beats
    d0 = done_cnt; a0 = ar_cnt;
    m_cmd_axis_tready = 1'b0;
    exp_ar(24'h002000, 8'd15);
    exp_ar(24'h002080, 8'd15);
    exp_ar(24'h002100, 8'd15);
    exp_ar(24'h002180, 8'd15);
    go(24'h002000, 64);
    cyc(100);
    chk("t3_outstanding_stalled", 64'(issued - emitted), 64'd32);
    chk("t3_ar_count_stalled", 64'(ar_cnt - a0), 64'd2);
    m_cmd_axis_tready = 1'b1;
    wait_done(d0, 400, "t3_done");
    chk("t3_max_outstanding", 64'(max_out <= 32), 64'd1);
    end_checks(d0, "t3");

    // Zero length
    d0 = done_cnt; a0 = ar_cnt;
    @(posedge aclk); #1;
    start = 1'b1; start_addr = 24'h009000; start_beats = 24'd0;
    @(posedge aclk); #1;
    start = 1'b0;
    chk("t4_zero_c1", 64'({done, m_mem_axi_arvalid, busy}), 64'({1'b1, 1'b0, 1'b0}));
    cyc(4);
    chk("t4_zero_done_once", 64'(done_cnt), 64'(d0 + 1));
    chk("t4_zero_no_ar", 64'(ar_cnt), 64'(a0));

    // Start while busy is ignored
    d0 = done_cnt;
    exp_ar(24'h003000, 8'd15);
    exp_ar(24'h003080, 8'd3);
    go(24'h003000, 20);
    cyc(3);
    start = 1'b1; start_addr = 24'h005000; start_beats = 24'd3;
    cyc(1);
    start = 1'b0;
    wait_done(d0, 300, "t4_busy_done");
    end_checks(d0, "t4_busy");

    // Error response on beat 3 of 8
    d0 = done_cnt;
    err_addr = 24'h004010;
    exp_ar(24'h004000, 8'd7);
    go(24'h004000, 8);
    wait_done(d0, 200, "t5_done");
    end_checks(d0, "t5");
    chk("t5_rd_error_set", 64'(rd_error), 64'd1);
    err_addr = '1;
    d0 = done_cnt;
    exp_ar(24'h004100, 8'd0);
    go(24'h004100, 1);
    chk("t5_rd_error_cleared", 64'(rd_error), 64'd0);
    wait_done(d0, 200, "t5b_done");
    end_checks(d0, "t5b");

    // Reset mid-transfer with data stalled on the stream and an AR pending
    m_cmd_axis_tready = 1'b0;
    exp_ar(24'h007000, 8'd15);
    go(24'h007000, 20);
    cyc(1);
    m_mem_axi_arready = 1'b0;
    begin
      int n;
      n = 0;
      while (!(m_cmd_axis_tvalid && m_mem_axi_arvalid) && n < 60) begin cyc(1); n++; end
    end
    chk("t6_setup_tvalid_arvalid", 64'({m_cmd_axis_tvalid, m_mem_axi_arvalid}), 64'd3);
    #2 resetn = 1'b0;
    #1;
    chk("t6_async_rst_outs", 64'({busy, done, rd_error, m_mem_axi_arvalid, m_mem_axi_araddr, m_mem_axi_arlen,
                                 m_mem_axi_rready, m_cmd_axis_tvalid, m_cmd_axis_tlast}), 64'd0);
    chk("t6_async_rst_tdata", m_cmd_axis_tdata, 64'd0);
    exp_ar_q.delete();
    exp_beat_q.delete();
    cyc(3);
    resetn = 1'b1;
    m_mem_axi_arready = 1'b1;
    m_cmd_axis_tready = 1'b1;
    cyc(2);
    d0 = done_cnt;
    exp_ar(24'h008000, 8'd3);
    go(24'h008000, 4);
    wait_done(d0, 200, "t6_done");
    end_checks(d0, "t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
